// File: rtl/bitfusion_pkg.sv
// Shared types and constants for the Bit Fusion partial-sum accumulator slice.
// Saturation bounds are derived here so every user sees the same ACC_W limits.
package bitfusion_pkg;

  localparam int PSUM_W_DEF = 8;
  localparam int ACC_W_DEF  = 20;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_e;

  // Largest representable value of a w-bit accumulator.
  function automatic logic [63:0] sat_max(input int unsigned w, input logic is_signed);
    logic [63:0] ones;
    ones = {64{1'b1}} >> (64 - w);
    return is_signed ? (ones >> 1) : ones;
  endfunction

  function automatic logic [63:0] sat_min(input int unsigned w, input logic is_signed);
    return is_signed ? (64'd1 << (w - 1)) : 64'd0;
  endfunction

endpackage

// File: rtl/psum_sat_add.sv
// Extend a psum to accumulator width, add it, and flag range overflow.
// PSUM_ACC_SATURATE_EN clamps the sum on overflow; otherwise it wraps.
module psum_sat_add
  import bitfusion_pkg::*;
#(
  parameter int PSUM_W = PSUM_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PSUM_W-1:0] psum,
  input  logic              is_signed,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  localparam int EXT_W = ACC_W - PSUM_W;
`ifdef PSUM_ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] SMAX = ACC_W'(sat_max(ACC_W, 1'b1));
  localparam logic [ACC_W-1:0] SMIN = ACC_W'(sat_min(ACC_W, 1'b1));
  localparam logic [ACC_W-1:0] UMAX = ACC_W'(sat_max(ACC_W, 1'b0));
`endif

  logic [ACC_W:0] a_s;
  logic [ACC_W:0] b_s;
  logic [ACC_W:0] raw_s;
  logic           pad_s;

  // One guard bit above ACC_W holds the true sign/carry of the add.
  always_comb begin
    pad_s = is_signed & psum[PSUM_W-1];
    a_s   = {is_signed & acc[ACC_W-1], acc};
    b_s   = {{(EXT_W + 1){pad_s}}, psum};
    raw_s = a_s + b_s;
    if (is_signed) begin
      ovf = raw_s[ACC_W] ^ raw_s[ACC_W-1];
    end else begin
      ovf = raw_s[ACC_W];
    end
`ifdef PSUM_ACC_SATURATE_EN
    if (!ovf) begin
      sum = raw_s[ACC_W-1:0];
    end else if (is_signed) begin
      sum = raw_s[ACC_W] ? SMIN : SMAX;
    end else begin
      sum = UMAX;
    end
`else
    sum = raw_s[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates a programmable window of 8-bit psums into a wide result on a valid/ready port.
// Build option PSUM_ACC_SATURATE_EN selects clamping instead of wrap-around on overflow.
module psum_accumulator
  import bitfusion_pkg::*;
#(
  parameter int PSUM_W = PSUM_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PSUM_W-1:0] psum_in,
  input  logic              psum_valid,
  input  logic              psum_signed,
  output logic              psum_ready,
  input  logic [CNT_W-1:0]  acc_len,
  input  logic              flush,
  output logic [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]  acc_count,
  output logic              acc_ovf,
  output logic              acc_valid,
  input  logic              acc_ready
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W - 1){1'b0}}, 1'b1};

  acc_state_e       state_r;
  logic [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] len_r;
  logic             signed_r;
  logic             ovf_r;
  logic             valid_r;

  logic             take_in_s;
  logic             take_out_s;
  logic             in_accum_s;
  logic             start_s;
  logic [CNT_W-1:0] len_eff_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [ACC_W-1:0] add_acc_s;
  logic [ACC_W-1:0] add_sum_s;
  logic             add_signed_s;
  logic             add_ovf_s;

  // Upstream back-pressure: only HOLD waits on the downstream handshake.
  always_comb begin
    psum_ready = 1'b0;
    if (!rst_n) begin
      psum_ready = 1'b0;
    end else begin
      case (state_r)
        IDLE, ACCUM: psum_ready = 1'b1;
        HOLD:        psum_ready = acc_ready;
        default:     psum_ready = 1'b0;
      endcase
    end
  end

  // Handshakes and adder operand selection; a window start adds onto zero.
  always_comb begin
    take_in_s    = psum_valid & psum_ready;
    take_out_s   = valid_r & acc_ready;
    in_accum_s   = (state_r == ACCUM);
    start_s      = take_in_s & ~in_accum_s;
    len_eff_s    = (acc_len == {CNT_W{1'b0}}) ? CNT_ONE : acc_len;
    cnt_inc_s    = cnt_r + CNT_ONE;
    add_acc_s    = in_accum_s ? acc_r : {ACC_W{1'b0}};
    add_signed_s = in_accum_s ? signed_r : psum_signed;
  end

  psum_sat_add #(
    .PSUM_W (PSUM_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc       (add_acc_s),
    .psum      (psum_in),
    .is_signed (add_signed_s),
    .sum       (add_sum_s),
    .ovf       (add_ovf_s)
  );

  // Window FSM and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      acc_r    <= {ACC_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      len_r    <= CNT_ONE;
      signed_r <= 1'b0;
      ovf_r    <= 1'b0;
      valid_r  <= 1'b0;
    end else if (start_s) begin
      len_r    <= len_eff_s;
      signed_r <= psum_signed;
      acc_r    <= add_sum_s;
      cnt_r    <= CNT_ONE;
      ovf_r    <= 1'b0;
      if ((len_eff_s == CNT_ONE) || flush) begin
        state_r <= HOLD;
        valid_r <= 1'b1;
      end else begin
        state_r <= ACCUM;
        valid_r <= 1'b0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
        end
        ACCUM: begin
          if (take_in_s) begin
`ifdef PSUM_ACC_SATURATE_EN
            // Once clamped, the window keeps its rail value.
            if (!ovf_r) begin
              acc_r <= add_sum_s;
            end else begin
              acc_r <= acc_r;
            end
`else
            acc_r <= add_sum_s;
`endif
            cnt_r <= cnt_inc_s;
            ovf_r <= ovf_r | add_ovf_s;
            if ((cnt_inc_s == len_r) || flush) begin
              state_r <= HOLD;
              valid_r <= 1'b1;
            end else begin
              state_r <= ACCUM;
              valid_r <= 1'b0;
            end
          end else if (flush) begin
            state_r <= HOLD;
            valid_r <= 1'b1;
          end else begin
            state_r <= ACCUM;
            valid_r <= 1'b0;
          end
        end
        HOLD: begin
          if (take_out_s) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
          end else begin
            state_r <= HOLD;
            valid_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign acc_out   = acc_r;
  assign acc_count = cnt_r;
  assign acc_ovf   = ovf_r;
  assign acc_valid = valid_r;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed self-checking bench for psum_accumulator; a second 9-bit-accumulator
// instance exercises overflow (expectations follow PSUM_ACC_SATURATE_EN).
module tb_psum_accumulator;

  logic        clk;
  logic        rst_n;
  logic [7:0]  psum_in;
  logic        psum_valid;
  logic        psum_signed;
  logic        psum_ready;
  logic        psum_ready9;
  logic [7:0]  acc_len;
  logic        flush;
  logic [19:0] acc_out;
  logic [7:0]  acc_count;
  logic        acc_ovf;
  logic        acc_valid;
  logic [8:0]  acc_out9;
  logic [7:0]  acc_count9;
  logic        acc_ovf9;
  logic        acc_valid9;
  logic        acc_ready;

  int checks = 0;
  int errors = 0;

  psum_accumulator #(.PSUM_W(8), .ACC_W(20), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .psum_in(psum_in), .psum_valid(psum_valid),
    .psum_signed(psum_signed), .psum_ready(psum_ready), .acc_len(acc_len),
    .flush(flush), .acc_out(acc_out), .acc_count(acc_count), .acc_ovf(acc_ovf),
    .acc_valid(acc_valid), .acc_ready(acc_ready)
  );

  psum_accumulator #(.PSUM_W(8), .ACC_W(9), .CNT_W(8)) dut9 (
    .clk(clk), .rst_n(rst_n), .psum_in(psum_in), .psum_valid(psum_valid),
    .psum_signed(psum_signed), .psum_ready(psum_ready9), .acc_len(acc_len),
    .flush(flush), .acc_out(acc_out9), .acc_count(acc_count9), .acc_ovf(acc_ovf9),
    .acc_valid(acc_valid9), .acc_ready(acc_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v, input logic s, input logic f);
    psum_in     = v;
    psum_signed = s;
    flush       = f;
    psum_valid  = 1'b1;
    tick();
  endtask

  task automatic idle();
    psum_valid = 1'b0;
    flush      = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; psum_in = 8'd0; psum_valid = 1'b0; psum_signed = 1'b0;
    acc_len = 8'd4; flush = 1'b0; acc_ready = 1'b1;
    #1;
    chk("ready_in_reset", {31'd0, psum_ready}, 32'd0);
    tick();
    tick();
    chk("rst_out", {12'd0, acc_out}, 32'd0);
    chk("rst_cnt", {24'd0, acc_count}, 32'd0);
    chk("rst_valid", {31'd0, acc_valid}, 32'd0);
    chk("rst_ovf", {31'd0, acc_ovf}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", {31'd0, psum_ready}, 32'd1);

    // len 4 signed: 3 - 5 + 7 + 1 = 6
    send(8'd3, 1'b1, 1'b0);
    send(8'hFB, 1'b1, 1'b0);
    send(8'd7, 1'b1, 1'b0);
    chk("t1_not_yet_valid", {31'd0, acc_valid}, 32'd0);
    send(8'd1, 1'b1, 1'b0);
    chk("t1_valid", {31'd0, acc_valid}, 32'd1);
    chk("t1_out", {12'd0, acc_out}, 32'd6);
    chk("t1_cnt", {24'd0, acc_count}, 32'd4);
    chk("t1_ovf", {31'd0, acc_ovf}, 32'd0);
    idle();
    chk("t1_drained", {31'd0, acc_valid}, 32'd0);

    // len 2: unsigned FF+FF, then signed FF+FF starting in HOLD
    acc_len = 8'd2;
    send(8'hFF, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b0);
    chk("t2_u_out", {12'd0, acc_out}, 32'h1FE);
    chk("t2_u_valid", {31'd0, acc_valid}, 32'd1);
    send(8'hFF, 1'b1, 1'b0);
    chk("t2_restart_valid", {31'd0, acc_valid}, 32'd0);
    chk("t2_restart_cnt", {24'd0, acc_count}, 32'd1);
    send(8'hFF, 1'b1, 1'b0);
    chk("t2_s_out", {12'd0, acc_out}, 32'hFFFFE);
    chk("t2_s_valid", {31'd0, acc_valid}, 32'd1);
    idle();

    // len 3 with a stalled downstream
    acc_len = 8'd3;
    acc_ready = 1'b0;
    send(8'd10, 1'b0, 1'b0);
    send(8'd20, 1'b0, 1'b0);
    send(8'd30, 1'b0, 1'b0);
    psum_in = 8'd5;
    psum_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_ready", {31'd0, psum_ready}, 32'd0);
      chk("t3_stall_out", {12'd0, acc_out}, 32'd60);
      chk("t3_stall_valid", {31'd0, acc_valid}, 32'd1);
      tick();
    end
    chk("t3_stall_cnt", {24'd0, acc_count}, 32'd3);
    acc_ready = 1'b1;
    send(8'd5, 1'b0, 1'b0);
    chk("t3_new_valid", {31'd0, acc_valid}, 32'd0);
    chk("t3_new_out", {12'd0, acc_out}, 32'd5);
    chk("t3_new_cnt", {24'd0, acc_count}, 32'd1);
    send(8'd6, 1'b0, 1'b0);
    send(8'd7, 1'b0, 1'b0);
    chk("t3_win2_out", {12'd0, acc_out}, 32'd18);
    chk("t3_win2_cnt", {24'd0, acc_count}, 32'd3);
    chk("t3_win2_valid", {31'd0, acc_valid}, 32'd1);
    idle();

    // len 8 with flush riding on the 3rd psum, then a bare flush
    acc_len = 8'd8;
    send(8'd1, 1'b0, 1'b0);
    send(8'd2, 1'b0, 1'b0);
    send(8'd3, 1'b0, 1'b1);
    chk("t4a_out", {12'd0, acc_out}, 32'd6);
    chk("t4a_cnt", {24'd0, acc_count}, 32'd3);
    chk("t4a_valid", {31'd0, acc_valid}, 32'd1);
    idle();
    send(8'd1, 1'b0, 1'b0);
    send(8'd2, 1'b0, 1'b0);
    psum_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4b_out", {12'd0, acc_out}, 32'd3);
    chk("t4b_cnt", {24'd0, acc_count}, 32'd2);
    chk("t4b_valid", {31'd0, acc_valid}, 32'd1);
    idle();

    // 127 x 4 signed: fits in 20 bits, overflows the 9-bit instance
    acc_len = 8'd4;
    send(8'd127, 1'b1, 1'b0);
    send(8'd127, 1'b1, 1'b0);
    send(8'd127, 1'b1, 1'b0);
    send(8'd127, 1'b1, 1'b0);
    chk("t5_w20_out", {12'd0, acc_out}, 32'd508);
    chk("t5_w20_ovf", {31'd0, acc_ovf}, 32'd0);
    chk("t5_w9_valid", {31'd0, acc_valid9}, 32'd1);
    chk("t5_w9_ovf", {31'd0, acc_ovf9}, 32'd1);
`ifdef PSUM_ACC_SATURATE_EN
    chk("t5_w9_out", {23'd0, acc_out9}, 32'h0FF);
`else
    chk("t5_w9_out", {23'd0, acc_out9}, 32'h1FC);
`endif
    idle();

    // reset mid-window discards the partial sum
    send(8'd100, 1'b0, 1'b0);
    chk("t6_w9_ovf_cleared", {31'd0, acc_ovf9}, 32'd0);
    send(8'd100, 1'b0, 1'b0);
    rst_n = 1'b0;
    psum_valid = 1'b0;
    #1;
    chk("t6_ready_in_reset", {31'd0, psum_ready}, 32'd0);
    tick();
    chk("t6_rst_out", {12'd0, acc_out}, 32'd0);
    chk("t6_rst_cnt", {24'd0, acc_count}, 32'd0);
    chk("t6_rst_valid", {31'd0, acc_valid}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("t6_ready_after", {31'd0, psum_ready}, 32'd1);
    send(8'd1, 1'b0, 1'b0);
    send(8'd2, 1'b0, 1'b0);
    send(8'd3, 1'b0, 1'b0);
    chk("t6_no_early_valid", {31'd0, acc_valid}, 32'd0);
    send(8'd4, 1'b0, 1'b0);
    chk("t6_out", {12'd0, acc_out}, 32'd10);
    chk("t6_cnt", {24'd0, acc_count}, 32'd4);
    chk("t6_valid", {31'd0, acc_valid}, 32'd1);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
